// File: rtl/omem_pingpong.sv
// omem_pingpong: output memory for NoC node OWN_ADDR.
// Each timestep, it collects per-neuron {potential,spike} writes from the router.
// It answers read requests with the previous timestep's potentials from two ping-pong banks.
// After the last timestep it streams START, then HDR + SPIKE beats per timestep, then DONE.
// Optional build macro: SPARSE_DUMP_EN (DUMP_SPK emits only entries whose spike bit is 1).
module omem_pingpong #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned DATA_W   = 25,
  parameter int unsigned OWN_ADDR = 12,
  parameter int unsigned NEURONS  = 441,
  parameter int unsigned NUM_TS   = 2,
  localparam int unsigned PKT_W   = ADDR_W + OPC_W + DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             router_in_valid,
  output logic             router_in_ready,
  input  logic [PKT_W-1:0] router_in_data,
  output logic             router_out_valid,
  input  logic             router_out_ready,
  output logic [PKT_W-1:0] router_out_data,
  input  logic [7:0]       layer_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [15:0]      out_data,
  output logic             err
);

  localparam int unsigned IDX_W     = 15;
  localparam int unsigned TS_W      = 8;
  localparam int unsigned POT_DEPTH = 2 * NEURONS;
  localparam int unsigned SPK_DEPTH = NUM_TS * NEURONS;
  localparam int unsigned POT_AW    = $clog2(POT_DEPTH);
  localparam int unsigned SPK_AW    = (SPK_DEPTH > 1) ? $clog2(SPK_DEPTH) : 1;

  localparam logic [1:0] KIND_START = 2'd0;
  localparam logic [1:0] KIND_HDR   = 2'd1;
  localparam logic [1:0] KIND_SPK   = 2'd2;
  localparam logic [1:0] KIND_DONE  = 2'd3;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_DUMP_START,
    ST_DUMP_HDR,
    ST_DUMP_SPK,
    ST_DUMP_DONE
  } state_e;

  // Storage: potentials ping-pong on ts[0]; spikes kept for every timestep
  logic [DATA_W-2:0] pot_mem [POT_DEPTH];
  logic              spk_mem [SPK_DEPTH];

  state_e             state_q, state_d;
  logic               live_q, live_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [TS_W-1:0]    d_ts_q, d_ts_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic               resp_valid_q, resp_valid_d;
  logic [PKT_W-1:0]   resp_data_q, resp_data_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_kind_q, out_kind_d;
  logic [15:0]        out_data_q, out_data_d;

  logic [ADDR_W-1:0]  in_addr;
  logic [OPC_W-1:0]   in_opc;
  logic [DATA_W-1:0]  in_dat;
  logic               accept;
  logic               wr_en;
  logic [POT_AW-1:0]  pot_waddr, pot_raddr;
  logic [SPK_AW-1:0]  spk_waddr, spk_raddr, dmp_raddr;
  logic [TS_W-1:0]    prev_ts;
  logic [IDX_W-1:0]   dmp_rd_idx;
  logic               dmp_spk;
  logic               dmp_adv;
  logic               spk_beat_valid;
  logic [ADDR_W+OPC_W-1:0] resp_hdr;

  assign in_addr = router_in_data[PKT_W-1 -: ADDR_W];
  assign in_opc  = router_in_data[DATA_W +: OPC_W];
  assign in_dat  = router_in_data[DATA_W-1:0];

  // Inbound ready: collecting, out of reset, and the response slot is free or draining
  assign router_in_ready = live_q && (state_q == ST_COLLECT) &&
                           !(resp_valid_q && !router_out_ready);
  assign accept          = router_in_valid && router_in_ready;

  assign router_out_valid = resp_valid_q;
  assign router_out_data  = resp_data_q;
  assign out_valid        = out_valid_q;
  assign out_kind         = out_kind_q;
  assign out_data         = out_data_q;
  assign err              = err_q;

  // Memory address generation for collect writes, read responses and dump reads
  always_comb begin
    prev_ts    = (ts_q == '0) ? '0 : ts_q - TS_W'(1);
    pot_waddr  = POT_AW'((ts_q[0] ? NEURONS : 32'd0) + 32'(wr_idx_q));
    spk_waddr  = SPK_AW'(32'(ts_q) * NEURONS + 32'(wr_idx_q));
    pot_raddr  = POT_AW'((ts_q[0] ? 32'd0 : NEURONS) + 32'(rd_idx_q));
    spk_raddr  = SPK_AW'(32'(prev_ts) * NEURONS + 32'(rd_idx_q));
    dmp_rd_idx = ((state_q == ST_DUMP_SPK) && (idx_q != IDX_W'(NEURONS - 1))) ?
                 idx_q + IDX_W'(1) : '0;
    dmp_raddr  = SPK_AW'(32'(d_ts_q) * NEURONS + 32'(dmp_rd_idx));
    dmp_spk    = spk_mem[dmp_raddr];
    resp_hdr   = {ADDR_W'(in_opc[OPC_W-1:1]), OPC_W'(1)};
    dmp_adv    = !out_valid_q || out_ready;
`ifdef SPARSE_DUMP_EN
    spk_beat_valid = dmp_spk;
`else
    spk_beat_valid = 1'b1;
`endif
  end

  // Next-state: packet handling in COLLECT, beat sequencing in the dump states
  always_comb begin
    state_d      = state_q;
    live_d       = 1'b1;
    ts_d         = ts_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    d_ts_d       = d_ts_q;
    idx_d        = idx_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    out_valid_d  = out_valid_q;
    out_kind_d   = out_kind_q;
    out_data_d   = out_data_q;
    wr_en        = 1'b0;

    if (resp_valid_q && router_out_ready) begin
      resp_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_addr != ADDR_W'(OWN_ADDR)) begin
        err_d = 1'b1;
      end else if (!in_opc[0]) begin
        wr_en = 1'b1;
        if (wr_idx_q == IDX_W'(NEURONS - 1)) begin
          wr_idx_d = '0;
          rd_idx_d = '0;
          ts_d     = ts_q + TS_W'(1);
          if (ts_q == TS_W'(NUM_TS - 1)) begin
            state_d     = ST_DUMP_START;
            out_valid_d = 1'b1;
            out_kind_d  = KIND_START;
            out_data_d  = '0;
          end
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end else begin
        resp_valid_d = 1'b1;
        if (ts_q == '0) begin
          resp_data_d = {resp_hdr, DATA_W'(0)};
        end else if (rd_idx_q >= IDX_W'(NEURONS)) begin
          resp_data_d = {resp_hdr, DATA_W'(0)};
          err_d       = 1'b1;
        end else begin
          resp_data_d = {resp_hdr, pot_mem[pot_raddr], spk_mem[spk_raddr]};
          rd_idx_d    = rd_idx_q + IDX_W'(1);
        end
      end
    end

    if (dmp_adv) begin
      case (state_q)
        ST_DUMP_START: begin
          state_d     = ST_DUMP_HDR;
          out_valid_d = 1'b1;
          out_kind_d  = KIND_HDR;
          out_data_d  = {layer_id, d_ts_q};
        end
        ST_DUMP_HDR: begin
          state_d     = ST_DUMP_SPK;
          idx_d       = '0;
          out_valid_d = spk_beat_valid;
          out_kind_d  = KIND_SPK;
          out_data_d  = {IDX_W'(0), dmp_spk};
        end
        ST_DUMP_SPK: begin
          if (idx_q == IDX_W'(NEURONS - 1)) begin
            idx_d       = '0;
            out_valid_d = 1'b1;
            if (d_ts_q == TS_W'(NUM_TS - 1)) begin
              state_d    = ST_DUMP_DONE;
              d_ts_d     = '0;
              out_kind_d = KIND_DONE;
              out_data_d = '0;
            end else begin
              state_d    = ST_DUMP_HDR;
              d_ts_d     = d_ts_q + TS_W'(1);
              out_kind_d = KIND_HDR;
              out_data_d = {layer_id, d_ts_q + TS_W'(1)};
            end
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            out_valid_d = spk_beat_valid;
            out_kind_d  = KIND_SPK;
            out_data_d  = {dmp_rd_idx, dmp_spk};
          end
        end
        ST_DUMP_DONE: begin
          state_d     = ST_COLLECT;
          out_valid_d = 1'b0;
          out_kind_d  = '0;
          out_data_d  = '0;
          ts_d        = '0;
          wr_idx_d    = '0;
          rd_idx_d    = '0;
          idx_d       = '0;
          d_ts_d      = '0;
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COLLECT;
      live_q       <= 1'b0;
      ts_q         <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      d_ts_q       <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_kind_q   <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      live_q       <= live_d;
      ts_q         <= ts_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      d_ts_q       <= d_ts_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      out_valid_q  <= out_valid_d;
      out_kind_q   <= out_kind_d;
      out_data_q   <= out_data_d;
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pot_mem[pot_waddr] <= in_dat[DATA_W-1:1];
      spk_mem[spk_waddr] <= in_dat[0];
    end
  end

endmodule

// File: tb/tb_omem_pingpong.sv
// tb_omem_pingpong: directed bench for omem_pingpong (NEURONS=441, NUM_TS=2).
// Honours SPARSE_DUMP_EN when building the expected dump stream.
module tb_omem_pingpong;

  localparam int N = 441;

  logic        clk;
  logic        rst_n;
  logic        router_in_valid;
  logic        router_in_ready;
  logic [32:0] router_in_data;
  logic        router_out_valid;
  logic        router_out_ready;
  logic [32:0] router_out_data;
  logic [7:0]  layer_id;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [15:0] out_data;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [32:0] resp_q [$];
  logic [17:0] beat_q [$];

  omem_pingpong dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .router_in_valid  (router_in_valid),
    .router_in_ready  (router_in_ready),
    .router_in_data   (router_in_data),
    .router_out_valid (router_out_valid),
    .router_out_ready (router_out_ready),
    .router_out_data  (router_out_data),
    .layer_id         (layer_id),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_kind         (out_kind),
    .out_data         (out_data),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Record transfers half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (rst_n && router_out_valid && router_out_ready) resp_q.push_back(router_out_data);
    if (rst_n && out_valid && out_ready) beat_q.push_back({out_kind, out_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] wr_pkt(input int i);
    return {4'd12, 4'd0, 24'(i), 1'(i % 2)};
  endfunction

  function automatic logic [32:0] rd_pkt(input int src);
    return {4'd12, 3'(src), 1'b1, 25'd0};
  endfunction

  function automatic logic [32:0] rsp(input int src, input logic [24:0] d);
    return {4'(src), 4'd1, d};
  endfunction

  task automatic send(input logic [32:0] pkt);
    int n;
    n = 0;
    @(negedge clk);
    router_in_valid = 1'b1;
    router_in_data  = pkt;
    while (!router_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 64'(n < 100), 1);
    @(posedge clk);
    #1 router_in_valid = 1'b0;
  endtask

  task automatic write_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(wr_pkt(i));
  endtask

  task automatic read_one(input int src, input logic [24:0] d, input string tag);
    int n;
    logic [32:0] r;
    n = 0;
    send(rd_pkt(src));
    while (resp_q.size() == 0 && n < 10) begin
      @(negedge clk);
      #1 n++;
    end
    if (resp_q.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      r = resp_q.pop_front();
      chk(tag, r, rsp(src, d));
    end
  endtask

  task automatic pulse_reset();
    router_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] exp_q [$];
    logic [17:0] b;
    int n;
    bit done;

    rst_n            = 1'b0;
    router_in_valid  = 1'b1;
    router_in_data   = wr_pkt(5);
    router_out_ready = 1'b1;
    out_ready        = 1'b0;
    layer_id         = 8'hA5;

    // Reset with inbound valid held high
    repeat (3) @(negedge clk);
    chk("rst_in_ready", router_in_ready, 0);
    chk("rst_out_valid", router_out_valid, 0);
    chk("rst_out_data", router_out_data, 0);
    chk("rst_dump_valid", out_valid, 0);
    chk("rst_kind", out_kind, 0);
    chk("rst_dump_data", out_data, 0);
    chk("rst_err", err, 0);
    router_in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("rdy_at_release", router_in_ready, 0);
    @(posedge clk);
    #1 chk("rdy_one_cycle_later", router_in_ready, 1);

    // Read during timestep 0 returns zero data
    read_one(2, 25'd0, "rd_ts0");
    chk("err_after_ts0_read", err, 0);

    // Timestep 0 writes, then read back all entries in timestep 1
    write_range(0, N - 1);
    chk("no_dump_after_ts0", out_valid, 0);
    resp_q.delete();
    for (int i = 0; i < N; i++) send(rd_pkt(i % 5));
    repeat (4) @(negedge clk);
    #1 chk("resp_count", resp_q.size(), N);
    for (int i = 0; i < N && resp_q.size() > 0; i++) begin
      chk($sformatf("resp%0d", i), resp_q.pop_front(), rsp(i % 5, {24'(i), 1'(i % 2)}));
    end
    chk("err_after_reads", err, 0);

    // One read past the end of the timestep
    read_one(1, 25'd0, "rd_overrun");
    chk("err_after_overrun", err, 1);

    // Fresh run with a foreign-address packet in the middle of timestep 0
    pulse_reset();
    chk("err_cleared_by_reset", err, 0);
    write_range(0, 199);
    send({4'd3, 4'd0, 25'h1FFFFFF});
    chk("err_foreign_addr", err, 1);
    write_range(200, N - 1);
    write_range(0, N - 2);
    chk("no_early_dump", out_valid, 0);
    beat_q.delete();
    send(wr_pkt(N - 1));
    chk("dump_start_valid", out_valid, 1);
    chk("dump_start_kind", out_kind, 0);
    chk("dump_in_ready_low", router_in_ready, 0);

    // Full dump with out_ready toggling every cycle
    n = 0;
    done = 1'b0;
    while (!done && n < 8000) begin
      @(posedge clk);
      #1 out_ready = ~out_ready;
      n++;
      if (beat_q.size() > 0) begin
        b = beat_q[$];
        if (b[17:16] == 2'd3) done = 1'b1;
      end
    end
    chk("dump_done_seen", 64'(done), 1);
    out_ready = 1'b1;

    exp_q.push_back({2'd0, 16'd0});
    for (int t = 0; t < 2; t++) begin
      exp_q.push_back({2'd1, 8'hA5, 8'(t)});
      for (int i = 0; i < N; i++) begin
`ifdef SPARSE_DUMP_EN
        if (i % 2 == 1) exp_q.push_back({2'd2, 15'(i), 1'(i % 2)});
`else
        exp_q.push_back({2'd2, 15'(i), 1'(i % 2)});
`endif
      end
    end
    exp_q.push_back({2'd3, 16'd0});
    chk("beat_count", beat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      chk($sformatf("beat%0d", i), beat_q[i], exp_q[i]);
    end
    chk("err_kept_after_dump", err, 1);
    repeat (2) @(negedge clk);
    chk("idle_after_done", out_valid, 0);
    read_one(3, 25'd0, "rd_ts_reset_after_dump");

    // Second inference, interrupted by reset during the spike stream
    write_range(0, N - 1);
    write_range(0, N - 1);
    beat_q.delete();
    n = 0;
    while (beat_q.size() < 20 && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    chk("mid_dump_progress", 64'(beat_q.size() >= 20), 1);
    rst_n = 1'b0;
    #1 chk("mid_dump_rst_valid", out_valid, 0);
    chk("mid_dump_rst_kind", out_kind, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rdy_after_mid_rst", router_in_ready, 1);
    write_range(0, N - 1);
    chk("no_dump_after_rst_ts0", out_valid, 0);
    read_one(1, 25'd0, "rd_post_rst_idx0");
    read_one(4, {24'd1, 1'b1}, "rd_post_rst_idx1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
